// File: rtl/amplitude_modulator.sv
// Amplitude modulator for the synth voice path.
// The waveform sample is scaled by the envelope, and that result is then
// scaled by the master amplitude. Each scaling step computes
// floor(sample * gain / 256). Only the final result is registered, so the
// latency is exactly one clock.

// Gain stage: unsigned multiply, keeping the upper half of the product.
module am_gain_stage #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_sample,
  input  logic [W-1:0] i_gain,
  output logic [W-1:0] o_scaled
);
  logic [2*W-1:0] w_prod;

  assign w_prod   = {{W{1'b0}}, i_sample} * {{W{1'b0}}, i_gain};
  // Truncate by dropping the low W bits. There is no rounding or saturation:
  // full-scale inputs give 0xFE, which is always less than full scale.
  assign o_scaled = W'(w_prod >> W);
endmodule

module amplitude_modulator #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] waveform_in,
  input  logic [DATA_WIDTH-1:0] envelope_value,
  input  logic [DATA_WIDTH-1:0] master_amplitude,
  output logic [DATA_WIDTH-1:0] amplitude_out
);
  logic [DATA_WIDTH-1:0] w_s1;
  logic [DATA_WIDTH-1:0] w_s2;
  logic [DATA_WIDTH-1:0] r_amp;

  // Envelope scaling. This stage is combinational; s1 is not registered.
  am_gain_stage #(.W(DATA_WIDTH)) u_env_stage (
    .i_sample (waveform_in),
    .i_gain   (envelope_value),
    .o_scaled (w_s1)
  );

  // Master-volume scaling, fed directly from the envelope stage.
  am_gain_stage #(.W(DATA_WIDTH)) u_master_stage (
    .i_sample (w_s1),
    .i_gain   (master_amplitude),
    .o_scaled (w_s2)
  );

  // Single output register. Asserting reset clears it at once, which also
  // discards any result in flight. There is no enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_amp <= '0;
    else        r_amp <= w_s2;
  end

  assign amplitude_out = r_amp;
endmodule

// File: tb/tb_amplitude_modulator.sv
// Directed bench for amplitude_modulator. The expected values were worked
// out by hand as floor(floor(w*e/256)*m/256).
module tb_amplitude_modulator;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] waveform_in = 8'h00;
  logic [7:0] envelope_value = 8'h00;
  logic [7:0] master_amplitude = 8'h00;
  logic [7:0] amplitude_out;

  int checks = 0;
  int failures = 0;

  amplitude_modulator #(.DATA_WIDTH(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .waveform_in      (waveform_in),
    .envelope_value   (envelope_value),
    .master_amplitude (master_amplitude),
    .amplitude_out    (amplitude_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] exp);
    checks++;
    assert (amplitude_out === exp)
      else begin
        failures++;
        $error("FAIL %s: observed=%h expected=%h", tag, amplitude_out, exp);
      end
  endtask

  // Drive the inputs mid-cycle, let one rising edge pass, then sample 1 ns later.
  task automatic apply(input logic [7:0] w, input logic [7:0] e, input logic [7:0] m);
    @(negedge clk);
    waveform_in = w;
    envelope_value = e;
    master_amplitude = m;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    #2;
    check("reset_async", 8'h00);
    @(posedge clk); #1;
    check("reset_hold", 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_no_edge", 8'h00);

    // The first edge after release loads the current inputs, which are all 0.
    apply(8'hFF, 8'hFF, 8'hFF); check("full_scale", 8'hFD);
    apply(8'hFF, 8'h80, 8'hFF); check("half_env", 8'h7E);
    apply(8'hFF, 8'hFF, 8'h80); check("half_master", 8'h7F);
    apply(8'hFF, 8'h40, 8'h80); check("env40_m80", 8'h1F);
    apply(8'h80, 8'hFF, 8'hFF); check("wave80", 8'h7E);
    apply(8'h10, 8'hFF, 8'hFF); check("wave10", 8'h0E);
    apply(8'hC8, 8'h64, 8'hFF); check("wC8_e64", 8'h4D);
    apply(8'h01, 8'hFF, 8'hFF); check("wave01_trunc", 8'h00);
    apply(8'hFF, 8'h00, 8'hFF); check("zero_env", 8'h00);
    apply(8'h00, 8'hFF, 8'hFF); check("zero_wave", 8'h00);
    apply(8'hFF, 8'hFF, 8'h00); check("zero_master", 8'h00);

    // Latency: a mid-cycle change must not appear before the next edge,
    // and must appear right after it.
    apply(8'hFF, 8'hFF, 8'hFF); check("lat_pre", 8'hFD);
    @(negedge clk);
    waveform_in = 8'h10;
    #1;
    check("lat_no_early", 8'hFD);
    @(posedge clk); #1;
    check("lat_one_edge", 8'h0E);
    @(posedge clk); #1;
    check("lat_stable", 8'h0E);

    // Reset mid-operation: the output clears at once, stays cleared, and
    // recovers one edge after release.
    apply(8'hFF, 8'hFF, 8'hFF); check("rst_pre", 8'hFD);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_immediate", 8'h00);
    @(posedge clk); #1;
    check("rst_held1", 8'h00);
    @(posedge clk); #1;
    check("rst_held2", 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release_wait", 8'h00);
    @(posedge clk); #1;
    check("rst_recover", 8'hFD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
